// File: rtl/conv3x3_pkg.sv
// conv3x3_pkg: shared constants and state encodings for the 3x3 window loader.
//   WIN_SIZE   - number of slots in one 3x3 window
//   CNT_W      - width of the slot index / fill counter
//   DATA_W_DEF - default pixel width
//   win_state_e - single-buffer FSM state (FILL, FULL)
//   bank_st_e   - per-bank occupancy used by the ping-pong build
package conv3x3_pkg;
    localparam int WIN_SIZE   = 9;
    localparam int CNT_W      = 4;
    localparam int DATA_W_DEF = 8;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(WIN_SIZE - 1);

    typedef enum logic { FILL, FULL } win_state_e;
    typedef enum logic { BANK_EMPTY, BANK_FULL } bank_st_e;
endpackage

// File: rtl/conv3x3_win_bank.sv
// conv3x3_win_bank: nine pixel registers written one slot at a time.
// Ports:
//   clk, rst_n   - clock, async active-low reset (clears all slots to 0)
//   we_i         - write enable
//   widx_i       - slot index to write (0..8; other values write nothing)
//   wdata_i      - pixel to store
//   data_o       - all nine slots, slot i at data_o[i]
module conv3x3_win_bank
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we_i,
    input  logic [CNT_W-1:0]                 widx_i,
    input  logic [DATA_W-1:0]                wdata_i,
    output logic [WIN_SIZE-1:0][DATA_W-1:0]  data_o
);
    logic [WIN_SIZE-1:0][DATA_W-1:0] slot_q;

    // Per-slot decode keeps an out-of-range index from aliasing onto a slot.
    for (genvar i = 0; i < WIN_SIZE; i++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                slot_q[i] <= '0;
            else if (we_i && widx_i == CNT_W'(i))
                slot_q[i] <= wdata_i;
        end
    end

    assign data_o = slot_q;
endmodule

// File: rtl/conv3x3_window_load.sv
// conv3x3_window_load: serial-to-parallel 3x3 window assembler.
// Accepts one pixel per in_valid/in_ready beat into slots 0..8, then presents
// the whole window on data0..data8 under win_valid/win_ready.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   clear                 - synchronous flush of partial and held windows
//   in_valid/in_ready     - input pixel handshake, in_data pixel
//   win_valid/win_ready   - window handshake, data0..data8 slots in arrival order
//   fill_cnt              - next slot to be written (0..8)
// Build option: WIN_PINGPONG_EN selects two banks so filling overlaps with the
// consumer holding the previous window; undefined gives a single bank.
module conv3x3_window_load
    import conv3x3_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] data0,
    output logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] data2,
    output logic [DATA_W-1:0] data3,
    output logic [DATA_W-1:0] data4,
    output logic [DATA_W-1:0] data5,
    output logic [DATA_W-1:0] data6,
    output logic [DATA_W-1:0] data7,
    output logic [DATA_W-1:0] data8,
    output logic [CNT_W-1:0]  fill_cnt
);
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic             in_ready_q, win_valid_q;
    logic             accept, last_beat, rd_take;
    logic [WIN_SIZE-1:0][DATA_W-1:0] win_data;

    // clear wins over a same-cycle beat, so the beat is never written.
    assign accept     = in_valid & in_ready_q & ~clear;
    assign last_beat  = accept & (fill_cnt_q == LAST_SLOT);
    assign rd_take    = win_valid_q & win_ready;
    assign fill_cnt_d = last_beat ? '0 : fill_cnt_q + 1'b1;

`ifdef WIN_PINGPONG_EN
    logic     wr_sel_q;
    bank_st_e rd_st_q, wr_st_q;
    logic [WIN_SIZE-1:0][DATA_W-1:0] bank0_data, bank1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q    <= 1'b0;
            rd_st_q     <= BANK_EMPTY;
            wr_st_q     <= BANK_EMPTY;
            fill_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            win_valid_q <= 1'b0;
        end else if (clear) begin
            wr_sel_q    <= 1'b0;
            rd_st_q     <= BANK_EMPTY;
            wr_st_q     <= BANK_EMPTY;
            fill_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            win_valid_q <= 1'b0;
        end else begin
            if (accept)
                fill_cnt_q <= fill_cnt_d;
            if (last_beat) begin
                // Read bank free now (empty, or handed off this edge): swap.
                if (rd_st_q == BANK_EMPTY || rd_take) begin
                    wr_sel_q    <= ~wr_sel_q;
                    rd_st_q     <= BANK_FULL;
                    win_valid_q <= 1'b1;
                end else begin
                    wr_st_q    <= BANK_FULL;
                    in_ready_q <= 1'b0;
                end
            end else if (wr_st_q == BANK_FULL && rd_take) begin
                // Parked write bank moves to the read side on the handshake.
                wr_sel_q    <= ~wr_sel_q;
                wr_st_q     <= BANK_EMPTY;
                in_ready_q  <= 1'b1;
                rd_st_q     <= BANK_FULL;
                win_valid_q <= 1'b1;
            end else if (rd_take) begin
                rd_st_q     <= BANK_EMPTY;
                win_valid_q <= 1'b0;
            end
        end
    end

    conv3x3_win_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept & ~wr_sel_q),
        .widx_i (fill_cnt_q),
        .wdata_i(in_data),
        .data_o (bank0_data)
    );

    conv3x3_win_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept & wr_sel_q),
        .widx_i (fill_cnt_q),
        .wdata_i(in_data),
        .data_o (bank1_data)
    );

    // The read bank is always the one not being written.
    assign win_data = wr_sel_q ? bank0_data : bank1_data;
`else
    win_state_e state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            win_valid_q <= 1'b0;
        end else if (clear) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            win_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FILL: if (accept) begin
                    fill_cnt_q <= fill_cnt_d;
                    if (last_beat) begin
                        state_q     <= FULL;
                        in_ready_q  <= 1'b0;
                        win_valid_q <= 1'b1;
                    end
                end
                FULL: if (rd_take) begin
                    state_q     <= FILL;
                    in_ready_q  <= 1'b1;
                    win_valid_q <= 1'b0;
                end
                default: state_q <= FILL;
            endcase
        end
    end

    conv3x3_win_bank #(.DATA_W(DATA_W)) u_bank (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (accept),
        .widx_i (fill_cnt_q),
        .wdata_i(in_data),
        .data_o (win_data)
    );
`endif

    assign in_ready  = in_ready_q;
    assign win_valid = win_valid_q;
    assign fill_cnt  = fill_cnt_q;
    assign data0 = win_data[0];
    assign data1 = win_data[1];
    assign data2 = win_data[2];
    assign data3 = win_data[3];
    assign data4 = win_data[4];
    assign data5 = win_data[5];
    assign data6 = win_data[6];
    assign data7 = win_data[7];
    assign data8 = win_data[8];
endmodule

// File: tb/tb_conv3x3_window_load.sv
module tb_conv3x3_window_load;
`ifdef WIN_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic       in_valid = 1'b0, win_ready = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, win_valid;
    logic [7:0] data0, data1, data2, data3, data4, data5, data6, data7, data8;
    logic [3:0] fill_cnt;

    int checks = 0, errors = 0;
    logic [71:0] exp_q[$];

    always #5 clk = ~clk;

    conv3x3_window_load #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .win_valid(win_valid), .win_ready(win_ready),
        .data0(data0), .data1(data1), .data2(data2), .data3(data3), .data4(data4),
        .data5(data5), .data6(data6), .data7(data7), .data8(data8),
        .fill_cnt(fill_cnt)
    );

    function automatic logic [71:0] win_now();
        return {data8, data7, data6, data5, data4, data3, data2, data1, data0};
    endfunction

    // Window whose slot i holds base+i.
    function automatic logic [71:0] ramp(input logic [7:0] base);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[i*8 +: 8] = base + 8'(i);
        return w;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every window handshake pops one expected window.
    always @(negedge clk) begin
        if (rst_n && win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window got %0h", win_now());
            end else begin
                chk("window", win_now(), exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 72'(in_ready), 72'd1);
        chk("rst_win_valid", 72'(win_valid), 72'd0);
        chk("rst_fill_cnt", 72'(fill_cnt), 72'd0);
        chk("rst_data", win_now(), 72'd0);

        // Reset mid-fill discards partial window
        win_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        repeat (4) tick();
        chk("partial_cnt", 72'(fill_cnt), 72'd4);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cnt", 72'(fill_cnt), 72'd0);
        chk("midrst_data", win_now(), 72'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("midrst_in_ready", 72'(in_ready), 72'd1);
        chk("midrst_no_window", 72'(win_valid), 72'd0);

        // Continuous fill 0x10..0x18
        exp_q.push_back(ramp(8'h10));
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("cont_win_valid", 72'(win_valid), 72'd1);
        chk("cont_fill_cnt", 72'(fill_cnt), 72'd0);
        chk("cont_in_ready", 72'(in_ready), 72'(PP));
        tick();
        chk("cont_one_cycle", 72'(win_valid), 72'd0);
        chk("cont_ready_back", 72'(in_ready), 72'd1);

`ifndef WIN_PINGPONG_EN
        // Backpressure: window 0x20.. held, pending beat 0x30 waits
        win_ready = 1'b0;
        exp_q.push_back(ramp(8'h20));
        exp_q.push_back(ramp(8'h30));
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h20 + 8'(i);
            tick();
        end
        in_data = 8'h30;
        for (int c = 0; c < 5; c++) begin
            chk("bp_win_valid", 72'(win_valid), 72'd1);
            chk("bp_in_ready", 72'(in_ready), 72'd0);
            chk("bp_stable", win_now(), ramp(8'h20));
            tick();
        end
        chk("bp_cnt_held", 72'(fill_cnt), 72'd0);
        win_ready = 1'b1;
        tick();
        chk("bp_hs_valid", 72'(win_valid), 72'd0);
        chk("bp_hs_ready", 72'(in_ready), 72'd1);
        chk("bp_hs_cnt", 72'(fill_cnt), 72'd0);
        tick();
        chk("bp_10th_taken", 72'(fill_cnt), 72'd1);
        for (int i = 1; i < 9; i++) begin
            in_data = 8'h30 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_second_win", 72'(win_valid), 72'd1);
        tick();
`endif

        // Bubbles: 0xA0..0xA8 with idle cycles between beats
        exp_q.push_back(ramp(8'hA0));
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            tick();
            in_valid = 1'b0;
            if (i < 8) begin
                chk("bub_cnt", 72'(fill_cnt), 72'(i + 1));
                tick();
                chk("bub_cnt_hold", 72'(fill_cnt), 72'(i + 1));
            end
        end
        chk("bub_win_valid", 72'(win_valid), 72'd1);
        tick();

        // Clear with simultaneous beat drops the beat
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'h50 + 8'(i);
            tick();
        end
        chk("clr_pre_cnt", 72'(fill_cnt), 72'd4);
        clear   = 1'b1;
        in_data = 8'hFF;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", 72'(fill_cnt), 72'd0);
        chk("clr_win_valid", 72'(win_valid), 72'd0);
        exp_q.push_back(ramp(8'h01));
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h01 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("clr_after_win", 72'(win_valid), 72'd1);
        tick();

        // Clear flushes a held window
        win_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 8'h40 + 8'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("hold_before_clr", 72'(win_valid), 72'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_held_valid", 72'(win_valid), 72'd0);
        chk("clr_held_ready", 72'(in_ready), 72'd1);
        win_ready = 1'b1;
        repeat (2) tick();
        chk("clr_held_gone", 72'(win_valid), 72'd0);

`ifdef WIN_PINGPONG_EN
        // Ping-pong: 18 back-to-back beats, in_ready never drops
        exp_q.push_back(ramp(8'h60));
        exp_q.push_back(ramp(8'h69));
        in_valid = 1'b1;
        for (int i = 0; i < 18; i++) begin
            chk("pp_in_ready", 72'(in_ready), 72'd1);
            in_data = 8'h60 + 8'(i);
            tick();
            if (i == 8 || i == 17)
                chk("pp_win_valid", 72'(win_valid), 72'd1);
        end
        in_valid = 1'b0;
        tick();
`endif

        repeat (3) tick();
        chk("scoreboard_drained", 72'(exp_q.size()), 72'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv3x3_window_load.md
# conv3x3_window_load

Serial-to-parallel window assembler for the slow 3x3 convolution path. Accepts one pixel per valid/ready beat, fills nine window slots in order (slot 0 first), then presents the complete 3x3 window as nine parallel bytes with a valid/ready handshake. The downstream MAC sequencer steps through these nine bytes with its own slot counter; this block is the producer side of that parallel window.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- clear  in  1  synchronous flush of partial and held windows.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  DATA_W  pixel.
- win_valid  out  1  complete window presented.
- win_ready  in  1  consumer takes the window.
- data0 … data8  out  DATA_W each  window slots 0–8, in arrival order.
- fill_cnt  out  4  index of the next slot to write, 0..8.

## Operation
- Beat accepted when in_valid & in_ready at a rising edge. in_data is written to slot fill_cnt, and fill_cnt increments.
- fill_cnt == 8 on an accepted beat: the window is complete. fill_cnt wraps to 0 and the bank is marked full.
- State machine (single-buffer build):
  - FILL: in_ready=1, win_valid=0.
  - FULL: in_ready=0, win_valid=1.
  - FILL→FULL on the 9th accepted beat.
  - FULL→FILL on win_valid & win_ready.
- in_ready depends on registered state only. It has no combinational path from win_ready.
- data0..data8 hold stable while win_valid=1. While win_valid=0 their values are undefined to the consumer.
- clear:
  - Next cycle: fill_cnt=0, win_valid=0, state FILL.
  - clear has priority over a same-cycle input beat; that beat is dropped.
  - A window handshake in the same cycle as clear counts as completed.
- fill_cnt never exceeds 8. Values 9–15 are unreachable.
- Reset values: in_ready=1 once rst_n is high, win_valid=0, fill_cnt=0, data0..data8=0, state FILL.
- Reset asserted mid-fill or mid-hold discards all contents immediately.

## Timing
- Latency: 9th beat accepted at edge N gives win_valid=1 after edge N.
- Single-buffer throughput: at best one window per 10 cycles (9 fill cycles plus 1 handshake cycle).
- Handshake at edge M gives win_valid=0 and in_ready=1 after edge M.
- Input bubbles (in_valid=0) stall the fill without losing position.
- Consumer backpressure (win_ready=0) holds FULL indefinitely, with in_ready=0.

## Configuration
- WIN_PINGPONG_EN defined:
  - Two banks. Fill writes to the write bank while the read bank is presented.
  - On window completion, if the read bank is empty the banks swap and win_valid=1 after that edge.
  - If the read bank is still held, the write bank waits full and in_ready=0 until the handshake. The banks then swap at that edge and in_ready=1 after it.
  - Sustained throughput: one window per 9 cycles.
  - clear empties both banks.
- WIN_PINGPONG_EN undefined: single bank, behaviour exactly as under Operation.

## Structure
- Package conv3x3_pkg holds:
  - WIN_SIZE=9, CNT_W=4, default DATA_W.
  - The state enum (FILL, FULL; plus bank-status encoding for the ping-pong build).
- Sub-module conv3x3_win_bank: nine DATA_W registers with write enable and 4-bit write index, all outputs exposed. Instantiated once, or twice under WIN_PINGPONG_EN.

## Test plan
- Reset: rst_n low mid-stream → in_ready=1 (once rst_n is high), win_valid=0, fill_cnt=0, data0..data8=0x00. No window appears from the prior partial fill.
- Continuous fill: in_data 0x10..0x18 on 9 consecutive beats, win_ready=1 → win_valid high for exactly one cycle after the 9th edge, data0=0x10 … data8=0x18, fill_cnt=0.
- Backpressure: complete a window, hold win_ready=0 for 5 cycles → win_valid=1, data stable, in_ready=0 (single-buffer). The pending 10th beat is accepted only after the handshake.
- Bubbles: 9 beats 0xA0..0xA8 with in_valid low every other cycle → window in order, fill_cnt increments only on accepted beats.
- Clear: 4 beats accepted, then clear with a simultaneous beat 0xFF → fill_cnt=0, 0xFF dropped. The next 9 beats 0x01..0x09 give data0=0x01 … data8=0x09.
- Ping-pong (WIN_PINGPONG_EN): 18 back-to-back beats, win_ready=1 → win_valid after the 9th and 18th edges, in_ready never low, both windows correct.
